// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor inputs and occupancy/status outputs of the parking occupancy controller.
// The master side drives the beams and error clear; the slave side is the controller.
interface parking_occupancy_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             sens_a;
    logic             sens_b;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic [3:0]       bcd_ones;
    logic [3:0]       bcd_tens;
    logic             lot_full;
    logic             lot_empty;
    logic             entry_pulse;
    logic             exit_pulse;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output sens_a,
        output sens_b,
        output err_clr,
        input  count,
        input  bcd_ones,
        input  bcd_tens,
        input  lot_full,
        input  lot_empty,
        input  entry_pulse,
        input  exit_pulse,
        input  ovf_err,
        input  unf_err
    );

    modport slave (
        input  sens_a,
        input  sens_b,
        input  err_clr,
        output count,
        output bcd_ones,
        output bcd_tens,
        output lot_full,
        output lot_empty,
        output entry_pulse,
        output exit_pulse,
        output ovf_err,
        output unf_err
    );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Parking-lot occupancy controller: beam debounce, entry/exit FSM,
// saturating BCD occupancy count and sticky overflow/underflow flags.
module parking_occupancy_ctrl #(
    parameter int CAPACITY        = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 7
) (
    input logic                     clk,
    input logic                     rst_n,
    parking_occupancy_ctrl_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EN_A  = 3'd1;
    localparam logic [2:0] S_EN_AB = 3'd2;
    localparam logic [2:0] S_EN_B  = 3'd3;
    localparam logic [2:0] S_EX_B  = 3'd4;
    localparam logic [2:0] S_EX_AB = 3'd5;
    localparam logic [2:0] S_EX_A  = 3'd6;
    localparam logic [2:0] S_WAIT  = 3'd7;

    // bit 0 = outer beam A, bit 1 = inner beam B
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [2];

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             w_entry;
    logic             w_exit;
    logic             w_a_only;
    logic             w_b_only;
    logic             w_both;
    logic             w_none;

    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic             r_full;
    logic             r_empty;
    logic             r_entry_pulse;
    logic             r_exit_pulse;
    logic             r_ovf;
    logic             r_unf;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_ones_nxt;
    logic [3:0]       w_tens_nxt;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf_set;
    logic             w_unf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {bus.sens_b, bus.sens_a};
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synced value agrees with the accepted one restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_a_only =  r_db[0] & ~r_db[1];
    assign w_b_only = ~r_db[0] &  r_db[1];
    assign w_both   =  r_db[0] &  r_db[1];
    assign w_none   = ~r_db[0] & ~r_db[1];

    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                unique case (1'b1)
                    w_a_only: w_state_nxt = S_EN_A;
                    w_b_only: w_state_nxt = S_EX_B;
                    w_both:   w_state_nxt = S_WAIT;
                    default:  ;
                endcase
            end
            S_EN_A: begin
                unique case (1'b1)
                    w_both:  w_state_nxt = S_EN_AB;
                    w_none:  w_state_nxt = S_IDLE;
                    default: ;
                endcase
            end
            S_EN_AB: begin
                unique case (1'b1)
                    w_b_only: w_state_nxt = S_EN_B;
                    w_a_only: w_state_nxt = S_EN_A;
                    w_none:   w_state_nxt = S_IDLE;
                    default:  ;
                endcase
            end
            S_EN_B: begin
                unique case (1'b1)
                    w_none: begin
                        w_state_nxt = S_IDLE;
                        w_entry     = 1'b1;
                    end
                    w_both:  w_state_nxt = S_EN_AB;
                    default: ;
                endcase
            end
            S_EX_B: begin
                unique case (1'b1)
                    w_both:  w_state_nxt = S_EX_AB;
                    w_none:  w_state_nxt = S_IDLE;
                    default: ;
                endcase
            end
            S_EX_AB: begin
                unique case (1'b1)
                    w_a_only: w_state_nxt = S_EX_A;
                    w_b_only: w_state_nxt = S_EX_B;
                    w_none:   w_state_nxt = S_IDLE;
                    default:  ;
                endcase
            end
            S_EX_A: begin
                unique case (1'b1)
                    w_none: begin
                        w_state_nxt = S_IDLE;
                        w_exit      = 1'b1;
                    end
                    w_both:  w_state_nxt = S_EX_AB;
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (w_none) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_inc     = w_entry & (r_count != CAP_C);
    assign w_ovf_set = w_entry & (r_count == CAP_C);
    assign w_dec     = w_exit & (r_count != '0);
    assign w_unf_set = w_exit & (r_count == '0);

    // Digits track the binary count step by step, so no divider is needed
    always_comb begin
        w_cnt_nxt  = r_count;
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        if (w_inc) begin
            w_cnt_nxt = r_count + CNT_W'(1);
            if (r_ones == 4'd9) begin
                w_ones_nxt = 4'd0;
                w_tens_nxt = r_tens + 4'd1;
            end else begin
                w_ones_nxt = r_ones + 4'd1;
            end
        end else if (w_dec) begin
            w_cnt_nxt = r_count - CNT_W'(1);
            if (r_ones == 4'd0) begin
                w_ones_nxt = 4'd9;
                w_tens_nxt = r_tens - 4'd1;
            end else begin
                w_ones_nxt = r_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_ones        <= 4'd0;
            r_tens        <= 4'd0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_entry_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else begin
            r_count       <= w_cnt_nxt;
            r_ones        <= w_ones_nxt;
            r_tens        <= w_tens_nxt;
            r_full        <= (w_cnt_nxt == CAP_C);
            r_empty       <= (w_cnt_nxt == '0);
            r_entry_pulse <= w_inc;
            r_exit_pulse  <= w_dec;
            r_ovf         <= w_ovf_set | (r_ovf & ~bus.err_clr);
            r_unf         <= w_unf_set | (r_unf & ~bus.err_clr);
        end
    end

    assign bus.count       = r_count;
    assign bus.bcd_ones    = r_ones;
    assign bus.bcd_tens    = r_tens;
    assign bus.lot_full    = r_full;
    assign bus.lot_empty   = r_empty;
    assign bus.entry_pulse = r_entry_pulse;
    assign bus.exit_pulse  = r_exit_pulse;
    assign bus.ovf_err     = r_ovf;
    assign bus.unf_err     = r_unf;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl: table-driven sensor steps with a scoreboard
// queue, plus hand-written glitch, reset and wider-capacity BCD sequences.
module tb_parking_occupancy_ctrl;

    typedef struct {
        string name;
        logic  a;
        logic  b;
        logic  clr;
        int    hold;
        int    ent;
        int    ext;
        int    cnt;
        logic  full;
        logic  empty;
        logic  ovf;
        logic  unf;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst12_n = 1'b0;
    logic a       = 1'b0;
    logic b       = 1'b0;
    logic clr     = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tot_ent  = 0;
    int tot_ext  = 0;
    int tot_ent12 = 0;

    vec_t sb [$];
    vec_t tbl1 [$];
    vec_t tbl2 [$];
    vec_t tbl3 [$];

    always #5 clk = ~clk;

    parking_occupancy_ctrl_if #(.CNT_W(7)) bus2 ();
    parking_occupancy_ctrl_if #(.CNT_W(7)) bus12 ();

    assign bus2.sens_a   = a;
    assign bus2.sens_b   = b;
    assign bus2.err_clr  = clr;
    assign bus12.sens_a  = a;
    assign bus12.sens_b  = b;
    assign bus12.err_clr = clr;

    parking_occupancy_ctrl #(
        .CAPACITY(2), .DEBOUNCE_CYCLES(4), .CNT_W(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    parking_occupancy_ctrl #(
        .CAPACITY(12), .DEBOUNCE_CYCLES(4), .CNT_W(7)
    ) dut12 (
        .clk(clk), .rst_n(rst12_n), .bus(bus12.slave)
    );

    always @(negedge clk) begin
        if (bus2.entry_pulse) tot_ent++;
        if (bus2.exit_pulse) tot_ext++;
        if (bus12.entry_pulse) tot_ent12++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic va, input logic vb,
                                input logic vc, input int h, input int en,
                                input int ex, input int c, input logic fu,
                                input logic em, input logic ov, input logic un);
        vec_t v;
        v.name = n; v.a = va; v.b = vb; v.clr = vc; v.hold = h;
        v.ent = en; v.ext = ex; v.cnt = c;
        v.full = fu; v.empty = em; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic chk_state(input string nm, input int c, input logic fu,
                             input logic em, input logic ov, input logic un);
        chk({nm, ".count"}, 32'(bus2.count), 32'(c));
        chk({nm, ".ones"}, 32'(bus2.bcd_ones), 32'(c % 10));
        chk({nm, ".tens"}, 32'(bus2.bcd_tens), 32'(c / 10));
        chk({nm, ".full"}, 32'(bus2.lot_full), 32'(fu));
        chk({nm, ".empty"}, 32'(bus2.lot_empty), 32'(em));
        chk({nm, ".ovf"}, 32'(bus2.ovf_err), 32'(ov));
        chk({nm, ".unf"}, 32'(bus2.unf_err), 32'(un));
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        int   e0;
        int   x0;
        @(posedge clk); #1;
        e0  = tot_ent;
        x0  = tot_ext;
        a   = v.a;
        b   = v.b;
        clr = v.clr;
        sb.push_back(v);
        if (v.clr) begin
            @(posedge clk); #1;
            clr = 1'b0;
        end
        repeat (v.hold) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".entries"}, 32'(tot_ent - e0), 32'(e.ent));
        chk({e.name, ".exits"}, 32'(tot_ext - x0), 32'(e.ext));
        chk_state(e.name, e.cnt, e.full, e.empty, e.ovf, e.unf);
    endtask

    task automatic drive(input logic va, input logic vb);
        @(posedge clk); #1;
        a = va;
        b = vb;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        tbl1.push_back(mk("e1a",   1,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e1ab",  1,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e1b",   0,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e1c",   0,0,0,10, 1,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("e2a",   1,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("e2ab",  1,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("e2b",   0,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("e2c",   0,0,0,10, 1,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("e3a",   1,0,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("e3ab",  1,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("e3b",   0,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("e3c",   0,0,0,10, 0,0, 2, 1,0, 1,0));
        tbl1.push_back(mk("clr1",  0,0,1, 3, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("x1b",   0,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("x1ab",  1,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("x1a",   1,0,0,10, 0,0, 2, 1,0, 0,0));
        tbl1.push_back(mk("x1c",   0,0,0,10, 0,1, 1, 0,0, 0,0));
        tbl1.push_back(mk("x2b",   0,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("x2ab",  1,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("x2a",   1,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("x2c",   0,0,0,10, 0,1, 0, 0,1, 0,0));
        tbl1.push_back(mk("x3b",   0,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("x3ab",  1,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("x3a",   1,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("x3c",   0,0,0,10, 0,0, 0, 0,1, 0,1));
        tbl1.push_back(mk("clr2",  0,0,1, 3, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("ab_a",  1,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("ab_c",  0,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("w_ab",  1,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("w_b",   0,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("w_c",   0,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e4a",   1,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e4ab",  1,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e4b",   0,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl1.push_back(mk("e4c",   0,0,0,10, 1,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("bk_a",  1,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("bk_ab", 1,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("bk_a2", 1,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("bk_c",  0,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("g_a",   1,0,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("g_ab",  1,1,0,10, 0,0, 1, 0,0, 0,0));
        tbl1.push_back(mk("g_b",   0,1,0,10, 0,0, 1, 0,0, 0,0));

        tbl2.push_back(mk("g_c",   0,0,0,10, 1,0, 2, 1,0, 0,0));
        tbl2.push_back(mk("o_a",   1,0,0,10, 0,0, 2, 1,0, 0,0));
        tbl2.push_back(mk("o_ab",  1,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl2.push_back(mk("o_b",   0,1,0,10, 0,0, 2, 1,0, 0,0));
        tbl2.push_back(mk("o_c",   0,0,0,10, 0,0, 2, 1,0, 1,0));
        tbl2.push_back(mk("r_a",   1,0,0,10, 0,0, 2, 1,0, 1,0));
        tbl2.push_back(mk("r_ab",  1,1,0,10, 0,0, 2, 1,0, 1,0));

        tbl3.push_back(mk("e5a",   1,0,0,10, 0,0, 0, 0,1, 0,0));
        tbl3.push_back(mk("e5ab",  1,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl3.push_back(mk("e5b",   0,1,0,10, 0,0, 0, 0,1, 0,0));
        tbl3.push_back(mk("e5c",   0,0,0,10, 1,0, 1, 0,0, 0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_state("in_reset", 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_state("post_reset", 0, 0, 1, 0, 0);
        chk("post_reset.entries", 32'(tot_ent), 32'd0);

        foreach (tbl1[i]) apply(tbl1[i]);

        // 3-cycle dropout on B while in EN_B must not count as a clear
        begin
            int e0;
            @(posedge clk); #1;
            e0 = tot_ent;
            b  = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            b = 1'b1;
            repeat (12) @(posedge clk);
            @(negedge clk);
            chk("glitch.entries", 32'(tot_ent - e0), 32'd0);
            chk_state("glitch", 1, 0, 0, 0, 0);
        end

        foreach (tbl2[i]) apply(tbl2[i]);

        // async reset while in EN_AB, outputs must clear without a clock edge
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 1, 0, 0);
        chk("async_rst.entry_pulse", 32'(bus2.entry_pulse), 32'd0);
        chk("async_rst.exit_pulse", 32'(bus2.exit_pulse), 32'd0);
        a = 1'b0;
        b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            int e0;
            int x0;
            e0 = tot_ent;
            x0 = tot_ext;
            repeat (12) @(negedge clk);
            chk("rst_idle.entries", 32'(tot_ent - e0), 32'd0);
            chk("rst_idle.exits", 32'(tot_ext - x0), 32'd0);
            chk_state("rst_idle", 0, 0, 1, 0, 0);
        end

        foreach (tbl3[i]) apply(tbl3[i]);

        // capacity 12: BCD carry at 9->10 and borrow at 10->9
        @(negedge clk);
        rst12_n = 1'b1;
        begin
            int e0;
            e0 = tot_ent12;
            for (int k = 0; k < 10; k++) begin
                drive(1, 0); drive(1, 1); drive(0, 1); drive(0, 0);
            end
            @(negedge clk);
            chk("cap12_10.entries", 32'(tot_ent12 - e0), 32'd10);
            chk("cap12_10.count", 32'(bus12.count), 32'd10);
            chk("cap12_10.tens", 32'(bus12.bcd_tens), 32'd1);
            chk("cap12_10.ones", 32'(bus12.bcd_ones), 32'd0);
            chk("cap12_10.full", 32'(bus12.lot_full), 32'd0);
            drive(0, 1); drive(1, 1); drive(1, 0); drive(0, 0);
            @(negedge clk);
            chk("cap12_9.count", 32'(bus12.count), 32'd9);
            chk("cap12_9.tens", 32'(bus12.bcd_tens), 32'd0);
            chk("cap12_9.ones", 32'(bus12.bcd_ones), 32'd9);
            for (int k = 0; k < 4; k++) begin
                drive(1, 0); drive(1, 1); drive(0, 1); drive(0, 0);
            end
            @(negedge clk);
            chk("cap12_sat.count", 32'(bus12.count), 32'd12);
            chk("cap12_sat.tens", 32'(bus12.bcd_tens), 32'd1);
            chk("cap12_sat.ones", 32'(bus12.bcd_ones), 32'd2);
            chk("cap12_sat.full", 32'(bus12.lot_full), 32'd1);
            chk("cap12_sat.ovf", 32'(bus12.ovf_err), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
